// File: rtl/writeback_queue_if.sv
// Producer/register-file/decode-side signal bundle for writeback_queue.
// The queue takes the slave modport; whoever drives results and stalls takes the master.
interface writeback_queue_if #(
  parameter int WORD_SIZE = 16,
  parameter int REG_SIZE  = 2,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [REG_SIZE-1:0]  in_reg;
  logic [WORD_SIZE-1:0] in_data;
  logic                 wb_en;
  logic                 regWrite;
  logic [REG_SIZE-1:0]  regW;
  logic [WORD_SIZE-1:0] writeData;
  logic [REG_SIZE-1:0]  look1;
  logic [REG_SIZE-1:0]  look2;
  logic                 hit1;
  logic                 hit2;
  logic [WORD_SIZE-1:0] fwd1;
  logic [WORD_SIZE-1:0] fwd2;
  logic [CW-1:0]        count;

  modport master (
    output in_valid, in_reg, in_data, wb_en, look1, look2,
    input  in_ready, regWrite, regW, writeData, hit1, hit2, fwd1, fwd2, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, wb_en, look1, look2,
    output in_ready, regWrite, regW, writeData, hit1, hit2, fwd1, fwd2, count
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order result queue feeding the register file write port, with two youngest-match forwarding lookups.
// Accepted results drain no earlier than the next cycle; in_ready drops only when all DEPTH entries are full.
module writeback_queue #(
  parameter int WORD_SIZE = 16,
  parameter int REG_SIZE  = 2,
  parameter int DEPTH     = 4
) (
  input logic               Clk,
  input logic               Reset,
  writeback_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_SIZE-1:0]  ent_reg  [DEPTH];
  logic [WORD_SIZE-1:0] ent_data [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        cnt;

  logic not_empty;
  logic enq;
  logic deq;

  assign not_empty   = (cnt != '0);
  assign q.in_ready  = (cnt != CW'(DEPTH));
  assign enq         = q.in_valid && q.in_ready;
  assign deq         = q.wb_en && not_empty;

  assign q.regWrite  = deq;
  assign q.regW      = not_empty ? ent_reg[rd_ptr]  : '0;
  assign q.writeData = not_empty ? ent_data[rd_ptr] : '0;
  assign q.count     = cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      if (enq && !deq)      cnt <= cnt + CW'(1);
      else if (!enq && deq) cnt <= cnt - CW'(1);
    end
  end

  // Payload needs no reset: every output is qualified by cnt.
  always_ff @(posedge Clk) begin
    if (enq) begin
      ent_reg[wr_ptr]  <= q.in_reg;
      ent_data[wr_ptr] <= q.in_data;
    end
  end

  logic [PW-1:0]        idx;
  logic                 hit1_c, hit2_c;
  logic [WORD_SIZE-1:0] fwd1_c, fwd2_c;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    idx    = rd_ptr;
    hit1_c = 1'b0;
    hit2_c = 1'b0;
    fwd1_c = '0;
    fwd2_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < cnt) begin
        if (ent_reg[idx] == q.look1) begin
          hit1_c = 1'b1;
          fwd1_c = ent_data[idx];
        end
        if (ent_reg[idx] == q.look2) begin
          hit2_c = 1'b1;
          fwd2_c = ent_data[idx];
        end
      end
    end
  end

  assign q.hit1 = hit1_c;
  assign q.hit2 = hit2_c;
  assign q.fwd1 = fwd1_c;
  assign q.fwd2 = fwd2_c;
endmodule

// File: tb/tb_writeback_queue.sv
// Directed and random cycles against an unbounded-queue reference model of the write-back buffer.
module tb_writeback_queue;
  localparam int WS = 16;
  localparam int RS = 2;
  localparam int DP = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  writeback_queue_if #(.WORD_SIZE(WS), .REG_SIZE(RS), .DEPTH(DP)) bus ();

  writeback_queue #(.WORD_SIZE(WS), .REG_SIZE(RS), .DEPTH(DP)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .q     (bus)
  );

  typedef struct {
    logic [RS-1:0] r;
    logic [WS-1:0] d;
  } ent_t;

  ent_t mq[$];
  bit   model_valid = 1'b0;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // One clock cycle: drive, check settled outputs against the model, then advance both.
  task automatic cyc(input bit rst, input bit vld, input int r, input int d,
                     input bit wb, input int l1, input int l2);
    logic          e_ready, e_wr, e_h1, e_h2;
    logic [RS-1:0] e_regw;
    logic [WS-1:0] e_data, e_f1, e_f2;
    Reset        = rst;
    bus.in_valid = vld;
    bus.in_reg   = RS'(r);
    bus.in_data  = WS'(d);
    bus.wb_en    = wb;
    bus.look1    = RS'(l1);
    bus.look2    = RS'(l2);
    #1;
    e_ready = (mq.size() != DP);
    e_wr    = wb && (mq.size() != 0);
    e_regw  = (mq.size() != 0) ? mq[0].r : '0;
    e_data  = (mq.size() != 0) ? mq[0].d : '0;
    e_h1 = 1'b0; e_f1 = '0; e_h2 = 1'b0; e_f2 = '0;
    for (int k = mq.size() - 1; k >= 0; k--) begin
      if (!e_h1 && mq[k].r == RS'(l1)) begin e_h1 = 1'b1; e_f1 = mq[k].d; end
      if (!e_h2 && mq[k].r == RS'(l2)) begin e_h2 = 1'b1; e_f2 = mq[k].d; end
    end
    if (model_valid) begin
      chk("in_ready",  32'(bus.in_ready),  32'(e_ready));
      chk("count",     32'(bus.count),     32'(mq.size()));
      chk("regWrite",  32'(bus.regWrite),  32'(e_wr));
      chk("regW",      32'(bus.regW),      32'(e_regw));
      chk("writeData", 32'(bus.writeData), 32'(e_data));
      chk("hit1",      32'(bus.hit1),      32'(e_h1));
      chk("fwd1",      32'(bus.fwd1),      32'(e_f1));
      chk("hit2",      32'(bus.hit2),      32'(e_h2));
      chk("fwd2",      32'(bus.fwd2),      32'(e_f2));
    end
    if (rst) begin
      mq.delete();
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (e_wr) void'(mq.pop_front());
      if (vld && e_ready) mq.push_back('{r: RS'(r), d: WS'(d)});
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_reg = '0; bus.in_data = '0;
    bus.wb_en = 1'b0; bus.look1 = '0; bus.look2 = '0;
    #2;

    // reset held two cycles while a producer is offering a result
    cyc(1, 1, 1, 'h5555, 1, 1, 0);
    cyc(1, 1, 1, 'h5555, 1, 1, 0);

    // single result, then idle
    cyc(0, 1, 2, 'h1234, 1, 2, 0);
    cyc(0, 0, 0, 0, 1, 2, 0);
    cyc(0, 0, 0, 0, 1, 2, 0);

    // fill while stalled; fifth result is held until space opens
    for (int i = 0; i < 4; i++) cyc(0, 1, i, 'hA0 + i, 0, i, 0);
    cyc(0, 1, 0, 'hA4, 0, 0, 3);
    cyc(0, 1, 0, 'hA4, 0, 0, 3);
    cyc(0, 1, 0, 'hA4, 1, 0, 3);
    cyc(0, 1, 0, 'hA4, 1, 0, 3);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, 1);

    // steady-state simultaneous enqueue and dequeue past the pointer wrap
    cyc(0, 1, 1, 'hC0, 0, 1, 2);
    cyc(0, 1, 2, 'hC1, 0, 1, 2);
    for (int i = 0; i < 6; i++) cyc(0, 1, (i + 3) % 4, 'hD0 + i, 1, 1, 2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 2);

    // youngest match wins; same-cycle enqueue not visible until next cycle
    cyc(0, 1, 1, 'hAAAA, 0, 1, 2);
    cyc(0, 1, 1, 'hBBBB, 0, 1, 2);
    cyc(0, 1, 3, 'h0007, 0, 1, 2);
    cyc(0, 1, 2, 'h2222, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 1, 2);

    // reset while draining discards the rest
    for (int i = 0; i < 3; i++) cyc(0, 1, i + 1, 'hE0 + i, 0, 1, 3);
    cyc(1, 0, 0, 0, 1, 1, 3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 2, 3);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
          ($urandom_range(0, 9) < 5),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
